mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001: Parameters: none; all data and address paths SHALL be 32 bits.
REQ-002: clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003: rst  input  1  reset, asynchronous and active-high.
REQ-004: imemreq_val  input  1  instruction fetch request valid.
REQ-005: imemreq_rdy  output  1  fetch request accepted this cycle.
REQ-006: imemreq_addr  input  32  fetch word address.
REQ-007: imemresp_val  output  1  fetch response valid.
REQ-008: imemresp_rdy  input  1  fetch response consumed.
REQ-009: imemresp_data  output  32  fetched word.
REQ-010: dmemreq_val  input  1  data request valid.
REQ-011: dmemreq_rdy  output  1  data request accepted this cycle.
REQ-012: dmemreq_type  input  1  0 = read, 1 = write.
REQ-013: dmemreq_addr  input  32  data word address.
REQ-014: dmemreq_wdata  input  32  store data.
REQ-015: dmemresp_val  output  1  data response valid.
REQ-016: dmemresp_rdy  input  1  data response consumed.
REQ-017: dmemresp_rdata  output  32  load data; 0 for write acks.
REQ-018: memreq_val  output  1  shared single-port memory access valid.
REQ-019: memreq_type  output  1  0 = read, 1 = write.
REQ-020: memreq_addr  output  32  word address, passed unmodified.
REQ-021: memreq_wdata  output  32  store data.
REQ-022: memresp_rdata  input  32  combinational same-cycle read data from memory.

Function
REQ-023: A request SHALL be accepted on a port only when val && rdy in the same cycle; rdy SHALL NOT depend on that port's own val.
REQ-024: Each port SHALL own a one-entry response register; a port is eligible only if its response register is empty, or is being drained this cycle (resp_val && resp_rdy).
REQ-025: At most one port SHALL be granted per cycle; memreq_* SHALL reflect the granted port's fields combinationally, and memreq_val = 0 when no grant.
REQ-026: Arbitration SHALL be round-robin: with both eligible ports valid, grant the port not granted most recently; with one, grant it.
REQ-027: The last-grant register SHALL update only on an accepted request.
REQ-028: On an accepted read, memresp_rdata SHALL be captured into that port's response register; resp_val SHALL assert the next cycle (latency 1).
REQ-029: On an accepted write, the memory write SHALL occur that cycle; the data port SHALL return resp_val next cycle with rdata = 0.
REQ-030: resp_val and resp data SHALL hold stable until resp_rdy is sampled high; drain and refill in the same cycle SHALL yield back-to-back responses with no bubble.
REQ-031: When resp_val is low, resp data SHALL read 0.
REQ-032: Response order per port SHALL equal acceptance order; no cross-port ordering is guaranteed.

Reset
REQ-033: While rst is high, all response registers SHALL clear: imemresp_val = dmemresp_val = 0, resp data = 0, imemreq_rdy = dmemreq_rdy = 0, memreq_val = 0.
REQ-034: Reset SHALL set last-grant = data port, so imem wins the first conflict.
REQ-035: Reset mid-transaction SHALL discard any pending response; the next cycle after rst falls SHALL behave as the first post-reset cycle.

Structure
REQ-036: Package mem_arb_pkg SHALL hold the grant enum (GRANT_NONE, GRANT_IMEM, GRANT_DMEM) and the constants MEM_READ = 0 and MEM_WRITE = 1.
REQ-037: The 2-way round-robin picker SHALL be the sub-module mem_arb_rr (inputs: two eligible-and-valid requests and last-grant; output: grant).

Verification
REQ-038: Fetch only: preload m[4] = 0xDEADBEEF, imemreq addr 4, resp_rdy = 1 -> imemresp_val next cycle with data 0xDEADBEEF, dmem idle.
REQ-039: Conflict after reset: both read (imem addr 1, dmem addr 2) each cycle -> grants alternate I, D, I, D; responses carry m[1] and m[2].
REQ-040: Store/load: dmem write 0x12345678 to addr 9, then read addr 9 -> write ack with rdata 0, then rdata 0x12345678.
REQ-041: Backpressure: imemresp_rdy = 0 for 3 cycles with a pending response -> imemreq_rdy = 0 and data held stable; dmem is still served; fetch resumes the cycle rdy rises.
REQ-042: Reset asserted while dmemresp_val = 1 -> dmemresp_val drops immediately, asynchronously; the first post-reset conflict is granted to imem.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Grant encoding and memory access type values used by the top and the picker.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_IMEM = 2'd1,
        GRANT_DMEM = 2'd2
    } grant_e;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of fetch, data and shared-memory handshake signals for mem_arb.
// The slave modport is the arbiter's view; master is the CPU-plus-memory side.
interface mem_arb_if;

    logic        imemreq_val;
    logic        imemreq_rdy;
    logic [31:0] imemreq_addr;
    logic        imemresp_val;
    logic        imemresp_rdy;
    logic [31:0] imemresp_data;

    logic        dmemreq_val;
    logic        dmemreq_rdy;
    logic        dmemreq_type;
    logic [31:0] dmemreq_addr;
    logic [31:0] dmemreq_wdata;
    logic        dmemresp_val;
    logic        dmemresp_rdy;
    logic [31:0] dmemresp_rdata;

    logic        memreq_val;
    logic        memreq_type;
    logic [31:0] memreq_addr;
    logic [31:0] memreq_wdata;
    logic [31:0] memresp_rdata;

    modport slave (
        input  imemreq_val, imemreq_addr, imemresp_rdy,
        input  dmemreq_val, dmemreq_type, dmemreq_addr, dmemreq_wdata, dmemresp_rdy,
        input  memresp_rdata,
        output imemreq_rdy, imemresp_val, imemresp_data,
        output dmemreq_rdy, dmemresp_val, dmemresp_rdata,
        output memreq_val, memreq_type, memreq_addr, memreq_wdata
    );

    modport master (
        output imemreq_val, imemreq_addr, imemresp_rdy,
        output dmemreq_val, dmemreq_type, dmemreq_addr, dmemreq_wdata, dmemresp_rdy,
        output memresp_rdata,
        input  imemreq_rdy, imemresp_val, imemresp_data,
        input  dmemreq_rdy, dmemresp_val, dmemresp_rdata,
        input  memreq_val, memreq_type, memreq_addr, memreq_wdata
    );

endinterface

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: on a conflict the port not granted last time wins.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic   ireq_i,
    input  logic   dreq_i,
    input  grant_e last_i,
    output grant_e grant_o
);

    always_comb begin
        grant_o = GRANT_NONE;
        if (ireq_i && dreq_i) begin
            grant_o = (last_i == GRANT_IMEM) ? GRANT_DMEM : GRANT_IMEM;
        end else if (ireq_i) begin
            grant_o = GRANT_IMEM;
        end else if (dreq_i) begin
            grant_o = GRANT_DMEM;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Arbitrates instruction-fetch and data ports onto one single-port memory,
// with a one-entry response register per port and round-robin on conflicts.
module mem_arb
    import mem_arb_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    mem_arb_if.slave bus
);

    logic        iresp_val_q, iresp_val_d;
    logic [31:0] iresp_data_q, iresp_data_d;
    logic        dresp_val_q, dresp_val_d;
    logic [31:0] dresp_data_q, dresp_data_d;
    grant_e      last_q, last_d;
    grant_e      grant;

    logic i_elig, d_elig, ireq, dreq;

    // A port may take a new request if its response slot is free or draining now.
    assign i_elig = !iresp_val_q || bus.imemresp_rdy;
    assign d_elig = !dresp_val_q || bus.dmemresp_rdy;
    assign ireq   = !rst && bus.imemreq_val && i_elig;
    assign dreq   = !rst && bus.dmemreq_val && d_elig;

    mem_arb_rr u_rr (
        .ireq_i  (ireq),
        .dreq_i  (dreq),
        .last_i  (last_q),
        .grant_o (grant)
    );

    // Ready looks only at the other port's request so it never depends on its own val.
    assign bus.imemreq_rdy = !rst && i_elig && !(dreq && last_q == GRANT_DMEM ? 1'b0 : dreq);
    assign bus.dmemreq_rdy = !rst && d_elig && !(ireq && last_q == GRANT_IMEM ? 1'b0 : ireq);

    assign bus.memreq_val   = (grant != GRANT_NONE);
    assign bus.memreq_type  = (grant == GRANT_DMEM) ? bus.dmemreq_type : MEM_READ;
    assign bus.memreq_addr  = (grant == GRANT_DMEM) ? bus.dmemreq_addr : bus.imemreq_addr;
    assign bus.memreq_wdata = (grant == GRANT_DMEM) ? bus.dmemreq_wdata : 32'd0;

    always_comb begin
        iresp_val_d  = iresp_val_q;
        iresp_data_d = iresp_data_q;
        dresp_val_d  = dresp_val_q;
        dresp_data_d = dresp_data_q;
        last_d       = last_q;

        if (grant != GRANT_NONE) begin
            last_d = grant;
        end

        // Data is cleared on drain so an empty slot always reads zero.
        if (grant == GRANT_IMEM) begin
            iresp_val_d  = 1'b1;
            iresp_data_d = bus.memresp_rdata;
        end else if (bus.imemresp_rdy) begin
            iresp_val_d  = 1'b0;
            iresp_data_d = 32'd0;
        end

        if (grant == GRANT_DMEM) begin
            dresp_val_d  = 1'b1;
            dresp_data_d = (bus.dmemreq_type == MEM_WRITE) ? 32'd0 : bus.memresp_rdata;
        end else if (bus.dmemresp_rdy) begin
            dresp_val_d  = 1'b0;
            dresp_data_d = 32'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iresp_val_q  <= 1'b0;
            iresp_data_q <= 32'd0;
            dresp_val_q  <= 1'b0;
            dresp_data_q <= 32'd0;
            last_q       <= GRANT_DMEM;
        end else begin
            iresp_val_q  <= iresp_val_d;
            iresp_data_q <= iresp_data_d;
            dresp_val_q  <= dresp_val_d;
            dresp_data_q <= dresp_data_d;
            last_q       <= last_d;
        end
    end

    assign bus.imemresp_val   = iresp_val_q;
    assign bus.imemresp_data  = iresp_data_q;
    assign bus.dmemresp_val   = dresp_val_q;
    assign bus.dmemresp_rdata = dresp_data_q;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with a small word-addressed memory model.
module tb_mem_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    mem_arb_if bus ();

    mem_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] wmem    [16];
    logic        written [16];

    function automatic logic [31:0] init_word(input logic [3:0] a);
        case (a)
            4'd1:    return 32'h1111_1111;
            4'd2:    return 32'h2222_2222;
            4'd4:    return 32'hDEAD_BEEF;
            4'd5:    return 32'hA5A5_A5A5;
            4'd6:    return 32'h6666_6666;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus.memreq_val && bus.memreq_type) begin
            wmem[bus.memreq_addr[3:0]]    <= bus.memreq_wdata;
            written[bus.memreq_addr[3:0]] <= 1'b1;
        end
    end

    assign bus.memresp_rdata = (written[bus.memreq_addr[3:0]] === 1'b1)
                             ? wmem[bus.memreq_addr[3:0]] : init_word(bus.memreq_addr[3:0]);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.imemreq_val   = 1'b0;
        bus.imemreq_addr  = 32'd0;
        bus.imemresp_rdy  = 1'b1;
        bus.dmemreq_val   = 1'b0;
        bus.dmemreq_type  = 1'b0;
        bus.dmemreq_addr  = 32'd0;
        bus.dmemreq_wdata = 32'd0;
        bus.dmemresp_rdy  = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.imemreq_val = 1'b1;
        bus.dmemreq_val = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_imemresp_val", bus.imemresp_val, 0);
        chk("rst_dmemresp_val", bus.dmemresp_val, 0);
        chk("rst_imemresp_data", bus.imemresp_data, 0);
        chk("rst_dmemresp_rdata", bus.dmemresp_rdata, 0);
        chk("rst_imemreq_rdy", bus.imemreq_rdy, 0);
        chk("rst_dmemreq_rdy", bus.dmemreq_rdy, 0);
        chk("rst_memreq_val", bus.memreq_val, 0);
        do_reset();
    endtask

    task automatic test_fetch();
        bus.imemreq_val  = 1'b1;
        bus.imemreq_addr = 32'd4;
        #1;
        chk("fetch_rdy", bus.imemreq_rdy, 1);
        chk("fetch_memreq_val", bus.memreq_val, 1);
        chk("fetch_memreq_addr", bus.memreq_addr, 32'd4);
        chk("fetch_memreq_type", bus.memreq_type, 0);
        @(negedge clk);
        bus.imemreq_val = 1'b0;
        #1;
        chk("fetch_resp_val", bus.imemresp_val, 1);
        chk("fetch_resp_data", bus.imemresp_data, 32'hDEAD_BEEF);
        chk("fetch_dmem_idle", bus.dmemresp_val, 0);
        @(negedge clk);
        #1;
        chk("fetch_drained_val", bus.imemresp_val, 0);
        chk("fetch_drained_data", bus.imemresp_data, 0);
    endtask

    task automatic test_conflict();
        logic prev_i;
        prev_i = 1'b0;
        do_reset();
        bus.imemreq_val  = 1'b1;
        bus.imemreq_addr = 32'd1;
        bus.dmemreq_val  = 1'b1;
        bus.dmemreq_addr = 32'd2;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin
                bus.imemreq_val = 1'b0;
                bus.dmemreq_val = 1'b0;
            end
            #1;
            if (k > 0) begin
                if (prev_i) begin
                    chk("conf_iresp_val", bus.imemresp_val, 1);
                    chk("conf_iresp_data", bus.imemresp_data, 32'h1111_1111);
                    chk("conf_dresp_idle", bus.dmemresp_val, 0);
                end else begin
                    chk("conf_dresp_val", bus.dmemresp_val, 1);
                    chk("conf_dresp_data", bus.dmemresp_rdata, 32'h2222_2222);
                    chk("conf_iresp_idle", bus.imemresp_val, 0);
                end
            end
            if (k < 4) begin
                chk("conf_grant_i", bus.imemreq_rdy, (k % 2 == 0) ? 1 : 0);
                chk("conf_grant_d", bus.dmemreq_rdy, (k % 2 == 0) ? 0 : 1);
                chk("conf_memreq_addr", bus.memreq_addr, (k % 2 == 0) ? 32'd1 : 32'd2);
                prev_i = (k % 2 == 0);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_store_load();
        do_reset();
        bus.dmemreq_val   = 1'b1;
        bus.dmemreq_type  = 1'b1;
        bus.dmemreq_addr  = 32'd9;
        bus.dmemreq_wdata = 32'h1234_5678;
        #1;
        chk("st_rdy", bus.dmemreq_rdy, 1);
        chk("st_memreq_type", bus.memreq_type, 1);
        chk("st_memreq_wdata", bus.memreq_wdata, 32'h1234_5678);
        @(negedge clk);
        bus.dmemreq_type = 1'b0;
        #1;
        chk("st_ack_val", bus.dmemresp_val, 1);
        chk("st_ack_rdata", bus.dmemresp_rdata, 0);
        chk("ld_refill_rdy", bus.dmemreq_rdy, 1);
        chk("ld_memreq_type", bus.memreq_type, 0);
        @(negedge clk);
        bus.dmemreq_val = 1'b0;
        #1;
        chk("ld_resp_val", bus.dmemresp_val, 1);
        chk("ld_resp_rdata", bus.dmemresp_rdata, 32'h1234_5678);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.imemresp_rdy = 1'b0;
        bus.imemreq_val  = 1'b1;
        bus.imemreq_addr = 32'd5;
        bus.dmemreq_val  = 1'b1;
        bus.dmemreq_addr = 32'd2;
        #1;
        chk("bp_first_grant_i", bus.imemreq_rdy, 1);
        @(negedge clk);
        bus.imemreq_addr = 32'd6;
        for (int j = 0; j < 3; j++) begin
            #1;
            chk("bp_stall_rdy", bus.imemreq_rdy, 0);
            chk("bp_hold_val", bus.imemresp_val, 1);
            chk("bp_hold_data", bus.imemresp_data, 32'hA5A5_A5A5);
            chk("bp_dmem_served", bus.dmemreq_rdy, 1);
            if (j > 0) chk("bp_dmem_data", bus.dmemresp_rdata, 32'h2222_2222);
            @(negedge clk);
        end
        bus.imemresp_rdy = 1'b1;
        #1;
        chk("bp_resume_rdy", bus.imemreq_rdy, 1);
        chk("bp_resume_addr", bus.memreq_addr, 32'd6);
        chk("bp_resume_dmem_wait", bus.dmemreq_rdy, 0);
        @(negedge clk);
        bus.imemreq_val = 1'b0;
        bus.dmemreq_val = 1'b0;
        #1;
        chk("bp_resume_data", bus.imemresp_data, 32'h6666_6666);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.dmemresp_rdy = 1'b0;
        bus.dmemreq_val  = 1'b1;
        bus.dmemreq_addr = 32'd2;
        @(negedge clk);
        bus.dmemreq_val  = 1'b0;
        bus.imemreq_val  = 1'b1;
        bus.imemreq_addr = 32'd1;
        #1;
        chk("rm_pending_val", bus.dmemresp_val, 1);
        @(negedge clk);
        bus.imemreq_val = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("rm_async_val", bus.dmemresp_val, 0);
        chk("rm_async_rdata", bus.dmemresp_rdata, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.dmemresp_rdy = 1'b1;
        bus.imemreq_val  = 1'b1;
        bus.imemreq_addr = 32'd1;
        bus.dmemreq_val  = 1'b1;
        bus.dmemreq_addr = 32'd2;
        #1;
        chk("rm_post_grant_i", bus.imemreq_rdy, 1);
        chk("rm_post_grant_d", bus.dmemreq_rdy, 0);
        chk("rm_post_addr", bus.memreq_addr, 32'd1);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("rm_post_data", bus.imemresp_data, 32'h1111_1111);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            written[i] = 1'b0;
            wmem[i]    = 32'd0;
        end
        idle_inputs();
        test_reset();
        test_fetch();
        test_conflict();
        test_store_load();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
